// File: rtl/whack_mole_engine_pkg.sv
// Shared types and constants for the whack-a-mole engine.
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int HOLES  = 16;
  localparam int TIME_W = 7;

  // Taps 16,14,13,11 of a right-shifting register land on bit positions 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [HOLES-1:0] hole_onehot(input logic [3:0] h);
    return {{(HOLES-1){1'b0}}, 1'b1} << h;
  endfunction

endpackage

// File: rtl/whack_mole_engine_if.sv
// Game control inputs and status outputs of the whack-a-mole engine.
interface whack_mole_engine_if #(
  parameter int SCORE_W = 8
);

  logic                            inGame;
  logic                            spawn_tick;
  logic                            sec_tick;
  logic                            key_valid;
  logic [3:0]                      key_code;
  logic [whack_pkg::HOLES-1:0]     active_mask;
  logic [SCORE_W-1:0]              score;
  logic [SCORE_W-1:0]              miss_cnt;
  logic [whack_pkg::TIME_W-1:0]    time_left;
  logic                            hit_pulse;
  logic                            game_over;

  modport master (
    output inGame, spawn_tick, sec_tick, key_valid, key_code,
    input  active_mask, score, miss_cnt, time_left, hit_pulse, game_over
  );

  modport slave (
    input  inGame, spawn_tick, sec_tick, key_valid, key_code,
    output active_mask, score, miss_cnt, time_left, hit_pulse, game_over
  );

endinterface

// File: rtl/whack_mole_engine_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying the candidate hole each cycle.
module whack_lfsr
  import whack_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else begin
      q <= {fb, q[15:1]};
    end
  end

endmodule

// File: rtl/whack_mole_engine.sv
// Whack-a-mole round engine: mole slots, scoring, round timer.
// Optional macro WHACK_PENALTY_EN: a press that misses every mole costs one point.
module whack_mole_engine
  import whack_pkg::*;
#(
  parameter int          NUM_MOLES    = 3,
  parameter int          MOLE_LIFE    = 4,
  parameter int          GAME_SECONDS = 30,
  parameter int          SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic                clk,
  input logic                rst,
  whack_mole_engine_if.slave bus
);

  localparam logic [3:0]        LIFE_INIT = 4'(MOLE_LIFE);
  localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(GAME_SECONDS);

  state_e               state_q;
  logic [TIME_W-1:0]    time_q;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   miss_q, miss_d;
  logic                 hit_q;
  logic                 over_q;
  logic [HOLES-1:0]     mask_q, mask_d;
  logic [NUM_MOLES-1:0] slot_vld_q, slot_vld_d;
  logic [3:0]           slot_hole_q [NUM_MOLES];
  logic [3:0]           slot_hole_d [NUM_MOLES];
  logic [3:0]           slot_life_q [NUM_MOLES];
  logic [3:0]           slot_life_d [NUM_MOLES];

  logic [15:0]          lfsr_q;
  logic [3:0]           cand;
  logic [11:0]          unused_lfsr_hi;

  logic                 in_play;
  logic                 end_now;
  logic                 spawn_ok;
  logic                 spawn_done;
  logic                 any_hit;
  logic                 penalty;
  logic [3:0]           exp_cnt;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [3:0]         b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  function automatic logic [SCORE_W-1:0] sat_dec(input logic [SCORE_W-1:0] a);
    return (a == '0) ? a : a - SCORE_W'(1);
  endfunction

  whack_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign cand           = lfsr_q[3:0];
  assign unused_lfsr_hi = lfsr_q[15:4];

  // Slot update: hits beat expiry, and spawns only fill slots that were free before this cycle.
  always_comb begin
    in_play    = (state_q == ST_PLAY) && bus.inGame;
    end_now    = in_play && bus.sec_tick && (time_q <= TIME_W'(1));
    spawn_ok   = in_play && bus.spawn_tick && !mask_q[cand];
    spawn_done = 1'b0;
    any_hit    = 1'b0;
    exp_cnt    = '0;
    mask_d     = '0;
    slot_vld_d = slot_vld_q;
    for (int i = 0; i < NUM_MOLES; i++) begin
      slot_hole_d[i] = slot_hole_q[i];
      slot_life_d[i] = slot_life_q[i];
      if (in_play && bus.key_valid && slot_vld_q[i] && (slot_hole_q[i] == bus.key_code)) begin
        slot_vld_d[i] = 1'b0;
        any_hit       = 1'b1;
      end else if (in_play && bus.spawn_tick && slot_vld_q[i]) begin
        slot_life_d[i] = slot_life_q[i] - 4'd1;
        if (slot_life_q[i] == 4'd1) begin
          slot_vld_d[i] = 1'b0;
          exp_cnt       = exp_cnt + 4'd1;
        end
      end else if (spawn_ok && !slot_vld_q[i] && !spawn_done) begin
        slot_vld_d[i]  = 1'b1;
        slot_hole_d[i] = cand;
        slot_life_d[i] = LIFE_INIT;
        spawn_done     = 1'b1;
      end
      if (!in_play || end_now) begin
        slot_vld_d[i] = 1'b0;
      end
      if (slot_vld_d[i]) begin
        mask_d = mask_d | hole_onehot(slot_hole_d[i]);
      end
    end

`ifdef WHACK_PENALTY_EN
    penalty = in_play && bus.key_valid && !mask_q[bus.key_code];
`else
    penalty = 1'b0;
`endif

    if (any_hit) begin
      score_d = sat_add(score_q, 4'd1);
    end else if (penalty) begin
      score_d = sat_dec(score_q);
    end else begin
      score_d = score_q;
    end
    miss_d = sat_add(miss_q, exp_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld_q <= '0;
      mask_q     <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      mask_q     <= mask_d;
    end
  end

  // Hole and lifetime are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MOLES; i++) begin
      slot_hole_q[i] <= slot_hole_d[i];
      slot_life_q[i] <= slot_life_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      score_q <= '0;
      miss_q  <= '0;
      hit_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.inGame) begin
            state_q <= ST_PLAY;
            time_q  <= TIME_INIT;
            score_q <= '0;
            miss_q  <= '0;
          end
        end
        ST_PLAY: begin
          if (!bus.inGame) begin
            state_q <= ST_IDLE;
          end else begin
            score_q <= score_d;
            miss_q  <= miss_d;
            hit_q   <= any_hit;
            if (bus.sec_tick) begin
              if (time_q <= TIME_W'(1)) begin
                time_q  <= '0;
                state_q <= ST_OVER;
                over_q  <= 1'b1;
              end else begin
                time_q <= time_q - TIME_W'(1);
              end
            end
          end
        end
        ST_OVER: begin
          if (!bus.inGame) begin
            state_q <= ST_IDLE;
            over_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.active_mask = mask_q;
  assign bus.score       = score_q;
  assign bus.miss_cnt    = miss_q;
  assign bus.time_left   = time_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.game_over   = over_q;

endmodule

// File: tb/tb_whack_mole_engine.sv
// Directed bench for whack_mole_engine with a hole-level reference model checked every cycle.
module tb_whack_mole_engine;

  localparam int NM   = 3;
  localparam int ML   = 4;
  localparam int GS   = 30;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #10 clk = ~clk;

  whack_mole_engine_if #(.SCORE_W(SW)) bus ();

  whack_mole_engine #(
    .NUM_MOLES    (NM),
    .MOLE_LIFE    (ML),
    .GAME_SECONDS (GS),
    .SCORE_W      (SW),
    .LFSR_SEED    (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: remaining life per hole (0 = empty), counters, round phase.
  int          m_life [16];
  int          m_score = 0;
  int          m_miss  = 0;
  int          m_time  = 0;
  int          m_state = 0;
  bit          m_hit   = 1'b0;
  logic [15:0] m_lfsr  = 16'hACE1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int m_mask();
    int m = 0;
    for (int h = 0; h < 16; h++) if (m_life[h] != 0) m = m | (1 << h);
    return m;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int h = 0; h < 16; h++) if (m_life[h] != 0) n++;
    return n;
  endfunction

  task automatic m_clear();
    for (int h = 0; h < 16; h++) m_life[h] = 0;
  endtask

  task automatic model_step();
    int cand;
    int key;
    int nact;
    int exp_n;
    bit keyhit;
    bit cand_free;
    m_hit = 1'b0;
    if (!rst) begin
      m_clear();
      m_score = 0;
      m_miss  = 0;
      m_time  = 0;
      m_state = 0;
      m_lfsr  = 16'hACE1;
      return;
    end
    cand = int'(m_lfsr[3:0]);
    key  = int'(bus.key_code);
    case (m_state)
      0: if (bus.inGame) begin
        m_state = 1;
        m_time  = GS;
        m_score = 0;
        m_miss  = 0;
        m_clear();
      end
      1: if (!bus.inGame) begin
        m_state = 0;
        m_clear();
      end else begin
        keyhit    = bus.key_valid && (m_life[key] != 0);
        nact      = m_count();
        cand_free = (m_life[cand] == 0);
        exp_n     = 0;
        if (bus.spawn_tick) begin
          for (int h = 0; h < 16; h++) begin
            if (m_life[h] > 0 && !(keyhit && h == key)) begin
              m_life[h]--;
              if (m_life[h] == 0) exp_n++;
            end
          end
        end
        if (keyhit) begin
          m_life[key] = 0;
          m_score     = (m_score < SMAX) ? m_score + 1 : SMAX;
          m_hit       = 1'b1;
        end
`ifdef WHACK_PENALTY_EN
        else if (bus.key_valid && m_score > 0) begin
          m_score--;
        end
`endif
        m_miss = (m_miss + exp_n > SMAX) ? SMAX : m_miss + exp_n;
        if (bus.spawn_tick && nact < NM && cand_free) m_life[cand] = ML;
        if (bus.sec_tick) begin
          if (m_time <= 1) begin
            m_time  = 0;
            m_state = 2;
            m_clear();
          end else begin
            m_time--;
          end
        end
      end
      default: if (!bus.inGame) m_state = 0;
    endcase
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  endtask

  initial begin : monitor
    for (int h = 0; h < 16; h++) m_life[h] = 0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("active_mask", int'(bus.active_mask), m_mask());
      chk("score",       int'(bus.score),       m_score);
      chk("miss_cnt",    int'(bus.miss_cnt),    m_miss);
      chk("time_left",   int'(bus.time_left),   m_time);
      chk("hit_pulse",   int'(bus.hit_pulse),   int'(m_hit));
      chk("game_over",   int'(bus.game_over),   int'(m_state == 2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_spawn();
    bus.spawn_tick = 1'b1;
    step();
    bus.spawn_tick = 1'b0;
  endtask

  task automatic press(input int k);
    bus.key_valid = 1'b1;
    bus.key_code  = 4'(k);
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic new_round();
    bus.inGame = 1'b0;
    step();
    bus.inGame = 1'b1;
    step();
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got timeout, expected event", nm);
  endtask

  task automatic wait_cand_eq(input int v);
    int n = 0;
    while (int'(m_lfsr[3:0]) != v && n < 400) begin step(); n++; end
    if (n >= 400) bound_fail("wait_cand_eq");
  endtask

  task automatic wait_cand_free();
    int n = 0;
    while (m_life[int'(m_lfsr[3:0])] != 0 && n < 400) begin step(); n++; end
    if (n >= 400) bound_fail("wait_cand_free");
  endtask

  task automatic wait_cand_busy();
    int n = 0;
    while (m_life[int'(m_lfsr[3:0])] == 0 && n < 400) begin step(); n++; end
    if (n >= 400) bound_fail("wait_cand_busy");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    int c;
    int saved;
    int low_hole;
    bus.inGame     = 1'b0;
    bus.spawn_tick = 1'b0;
    bus.sec_tick   = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;

    repeat (3) step();
    chk("rst_mask",  int'(bus.active_mask), 0);
    chk("rst_score", int'(bus.score),       0);
    chk("rst_miss",  int'(bus.miss_cnt),    0);
    chk("rst_time",  int'(bus.time_left),   0);
    chk("rst_hit",   int'(bus.hit_pulse),   0);
    chk("rst_over",  int'(bus.game_over),   0);

    rst = 1'b1;
    step();
    chk("model_lfsr_first_step", int'(m_lfsr), 16'h5670);

    // Round start
    bus.inGame = 1'b1;
    step();
    chk("start_time",  int'(bus.time_left),   30);
    chk("start_score", int'(bus.score),       0);
    chk("start_mask",  int'(bus.active_mask), 0);

    // Spawn at hole 5 then whack it
    wait_cand_eq(5);
    pulse_spawn();
    chk("spawn5_mask", int'(bus.active_mask), 32'h0020);
    press(5);
    chk("hit5_score", int'(bus.score),       1);
    chk("hit5_pulse", int'(bus.hit_pulse),   1);
    chk("hit5_mask",  int'(bus.active_mask), 0);
    step();
    chk("hit5_pulse_drop", int'(bus.hit_pulse), 0);

    // Mole expires on its fourth tick
    new_round();
    wait_cand_free();
    c = int'(m_lfsr[3:0]);
    pulse_spawn();
    repeat (3) pulse_spawn();
    chk("expire_still_up", (int'(bus.active_mask) >> c) & 1, 1);
    pulse_spawn();
    chk("expire_gone", (int'(bus.active_mask) >> c) & 1, 0);
    chk("expire_miss", int'(bus.miss_cnt), 1);

    // Hit on the expiry cycle wins
    new_round();
    wait_cand_free();
    c = int'(m_lfsr[3:0]);
    pulse_spawn();
    repeat (3) pulse_spawn();
    bus.spawn_tick = 1'b1;
    press(c);
    bus.spawn_tick = 1'b0;
    chk("hitexp_score", int'(bus.score),    1);
    chk("hitexp_miss",  int'(bus.miss_cnt), 0);
    chk("hitexp_gone",  (int'(bus.active_mask) >> c) & 1, 0);

    // Full slots reject spawns; duplicate candidate rejected with a free slot
    new_round();
    for (int k = 0; k < 3; k++) begin
      wait_cand_free();
      pulse_spawn();
    end
    chk("full_count", $countones(bus.active_mask), 3);
    wait_cand_free();
    saved = int'(bus.active_mask);
    pulse_spawn();
    chk("full_no_spawn", int'(bus.active_mask), saved);
    low_hole = 0;
    for (int h = 0; h < 16; h++) if (m_life[h] == 1) low_hole = h;
    press(low_hole);
    chk("full_hit_count", $countones(bus.active_mask), 2);
    wait_cand_busy();
    saved = int'(bus.active_mask);
    pulse_spawn();
    chk("dup_no_spawn", int'(bus.active_mask), saved);

    // Round timeout
    new_round();
    wait_cand_free();
    c = int'(m_lfsr[3:0]);
    pulse_spawn();
    press(c);
    wait_cand_free();
    pulse_spawn();
    bus.sec_tick = 1'b1;
    repeat (29) step();
    chk("timer_one_left",   int'(bus.time_left), 1);
    chk("timer_mole_there", int'(bus.active_mask != 0), 1);
    step();
    bus.sec_tick = 1'b0;
    chk("timer_zero", int'(bus.time_left),   0);
    chk("timer_over", int'(bus.game_over),   1);
    chk("timer_mask", int'(bus.active_mask), 0);
    step();
    chk("over_hold_score", int'(bus.score), 1);
    bus.inGame = 1'b0;
    step();
    chk("idle_over_drop", int'(bus.game_over), 0);
    chk("idle_score_held", int'(bus.score),    1);

    // Score saturation
    new_round();
    for (int k = 0; k < SMAX + 3; k++) begin
      wait_cand_free();
      c = int'(m_lfsr[3:0]);
      pulse_spawn();
      press(c);
    end
    chk("score_sat", int'(bus.score), SMAX);

    // Miss saturation
    repeat (80) pulse_spawn();
    chk("miss_sat", int'(bus.miss_cnt), SMAX);

    // Wrong-key presses
    new_round();
    wait_cand_free();
    c = int'(m_lfsr[3:0]);
    pulse_spawn();
    press(c);
    chk("pen_base", int'(bus.score), 1);
    press((c + 1) % 16);
`ifdef WHACK_PENALTY_EN
    chk("pen_first", int'(bus.score), 0);
`else
    chk("pen_first", int'(bus.score), 1);
`endif
    press((c + 2) % 16);
`ifdef WHACK_PENALTY_EN
    chk("pen_second", int'(bus.score), 0);
`else
    chk("pen_second", int'(bus.score), 1);
`endif

    // Reset in the middle of play
    wait_cand_free();
    pulse_spawn();
    rst = 1'b0;
    step();
    chk("midrst_mask",  int'(bus.active_mask), 0);
    chk("midrst_score", int'(bus.score),       0);
    chk("midrst_time",  int'(bus.time_left),   0);
    rst = 1'b1;
    bus.inGame = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
